// File: rtl/vga_timing_640_480.sv
// vga_timing_640_480
// Raster timing generator for a 640x480 VGA mode, advanced by a pixel-rate
// enable so the block can run from a faster system clock.
//
// Ports
//   clk          system clock
//   i_sclr       asynchronous active-high reset; clears counters and frame pulse
//   i_px_clk     pixel-rate enable, one clk wide per pixel
//   o_hsync_en   high during the horizontal sync pulse
//   o_vsync_en   high during the vertical sync pulse
//   o_haddr_en   high in the visible horizontal region
//   o_vaddr_en   high in the visible vertical region
//   o_hidx       visible pixel column (0 outside the visible region)
//   o_vidx       visible line row (0 outside the visible region)
//   o_vga_hsync  active-low horizontal sync pin
//   o_vga_vsync  active-low vertical sync pin
//   o_frame_end  one-clk pulse in the cycle after the frame wraps
module vga_timing_640_480 #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_px_clk,
  output logic       o_hsync_en,
  output logic       o_vsync_en,
  output logic       o_haddr_en,
  output logic       o_vaddr_en,
  output logic [9:0] o_hidx,
  output logic [8:0] o_vidx,
  output logic       o_vga_hsync,
  output logic       o_vga_vsync,
  output logic       o_frame_end
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Region bounds are compared at 11 bits so an active width of 1024 still
  // decodes correctly against a 10-bit counter.
  localparam logic [10:0] H_ACT_END   = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END   = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [10:0] hcnt_x;
  logic [10:0] vcnt_x;
  logic        h_last;
  logic        v_last;
  logic        frame_wrap;
  logic        frame_end;
  logic        haddr_en;
  logic        vaddr_en;
  logic        hsync_en;
  logic        vsync_en;

  assign h_last     = (hcnt == H_LAST);
  assign v_last     = (vcnt == V_LAST);
  assign frame_wrap = i_px_clk & h_last & v_last;

  always_ff @(posedge clk or posedge i_sclr) begin
    if (i_sclr) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (i_px_clk) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge i_sclr) begin
    if (i_sclr) begin
      frame_end <= 1'b0;
    end else begin
      frame_end <= frame_wrap;
    end
  end

  // All raster outputs decode straight from the counter registers so they
  // change in the same cycle as the counters.
  always_comb begin
    hcnt_x   = {1'b0, hcnt};
    vcnt_x   = {1'b0, vcnt};
    haddr_en = (hcnt_x < H_ACT_END);
    vaddr_en = (vcnt_x < V_ACT_END);
    hsync_en = (hcnt_x >= H_SYNC_BEG) && (hcnt_x < H_SYNC_END);
    vsync_en = (vcnt_x >= V_SYNC_BEG) && (vcnt_x < V_SYNC_END);
  end

  always_comb begin
    o_haddr_en  = haddr_en;
    o_vaddr_en  = vaddr_en;
    o_hsync_en  = hsync_en;
    o_vsync_en  = vsync_en;
    o_hidx      = haddr_en ? hcnt : '0;
    o_vidx      = vaddr_en ? vcnt[8:0] : '0;
    o_vga_hsync = ~hsync_en;
    o_vga_vsync = ~vsync_en;
    o_frame_end = frame_end;
  end

endmodule
